// File: rtl/mnist_line_buffer_ctrl.sv
// Receive-side line buffer for the MNIST CNN input: four rotating row buffers
// feeding one raw 3x3 window per cycle, with a per-row "send next row" interrupt.
module mnist_line_buffer_ctrl #(
    parameter int IMG_W  = 28,
    parameter int DATA_W = 8
) (
    input  logic                axi_clk,
    input  logic                axi_rst,
    input  logic                i_data_valid,
    input  logic [DATA_W-1:0]   i_data,
    output logic [9*DATA_W-1:0] o_pixel_data,
    output logic                o_pixel_data_valid,
    output logic                o_intr,
    output logic                o_frame_done,
    output logic                o_overflow
);

    localparam int CW = $clog2(IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_RET  = CW'(IMG_W - 3);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_READ = 1'b1;

    logic [3:0][IMG_W-1:0][DATA_W-1:0] lb_q;

    logic [1:0]          wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic [CW-1:0]       wr_col_q, wr_col_d, rd_col_q, rd_col_d;
    logic [CW-1:0]       out_row_q, out_row_d;
    logic [2:0]          rows_filled_q, rows_filled_d;
    logic                state_q, state_d;
    logic [9*DATA_W-1:0] pix_q, win;
    logic                valid_q, intr_q, fd_q, ovf_q;
    logic                wr_full, wr_en, row_done;
    logic                rd_act, retire, frame_end;

    // A full ring drops the pixel instead of overwriting a row still being read.
    assign wr_full  = (rows_filled_q == 3'd4);
    assign wr_en    = i_data_valid && !wr_full;
    assign row_done = wr_en && (wr_col_q == COL_LAST);

    always_ff @(posedge axi_clk) begin
        if (wr_en) lb_q[wr_buf_q][wr_col_q] <= i_data;
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rows_filled_q >= 3'd3) state_d = ST_READ;
            ST_READ: if (rd_col_q == COL_RET)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_act    = (state_q == ST_READ);
        retire    = rd_act && (rd_col_q == COL_RET);
        frame_end = retire && (out_row_q == COL_RET);
    end

    // Window byte (3*row + col): row 0 is the oldest buffer, col 0 is leftmost.
    always_comb begin
        win = '0;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                win[(3*j+k)*DATA_W +: DATA_W] = lb_q[rd_buf_q + 2'(j)][rd_col_q + CW'(k)];
            end
        end
    end

    always_comb begin
        wr_col_d      = wr_col_q;
        wr_buf_d      = wr_buf_q;
        rd_col_d      = rd_col_q;
        rd_buf_d      = rd_buf_q;
        out_row_d     = out_row_q;
        rows_filled_d = rows_filled_q;
        if (wr_en) begin
            if (row_done) begin
                wr_col_d = '0;
                wr_buf_d = wr_buf_q + 2'd1;
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end
        if (rd_act) rd_col_d = retire ? '0 : rd_col_q + 1'b1;
        if (retire) begin
            rd_buf_d  = rd_buf_q + 2'd1;
            out_row_d = out_row_q + 1'b1;
        end
        case ({row_done, retire})
            2'b10:   rows_filled_d = rows_filled_q + 3'd1;
            2'b01:   rows_filled_d = rows_filled_q - 3'd1;
            default: rows_filled_d = rows_filled_q;
        endcase
        // The two trailing rows of a frame never form a window; restart at the writer.
        if (frame_end) begin
            out_row_d     = '0;
            rd_buf_d      = wr_buf_d;
            rows_filled_d = row_done ? 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            wr_buf_q      <= '0;
            wr_col_q      <= '0;
            rd_buf_q      <= '0;
            rd_col_q      <= '0;
            out_row_q     <= '0;
            rows_filled_q <= '0;
            pix_q         <= '0;
            valid_q       <= 1'b0;
            intr_q        <= 1'b0;
            fd_q          <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            wr_buf_q      <= wr_buf_d;
            wr_col_q      <= wr_col_d;
            rd_buf_q      <= rd_buf_d;
            rd_col_q      <= rd_col_d;
            out_row_q     <= out_row_d;
            rows_filled_q <= rows_filled_d;
            if (rd_act) pix_q <= win;
            valid_q       <= rd_act;
            intr_q        <= retire;
            fd_q          <= frame_end;
            ovf_q         <= ovf_q | (i_data_valid && wr_full);
        end
    end

    assign o_pixel_data       = pix_q;
    assign o_pixel_data_valid = valid_q;
    assign o_intr             = intr_q;
    assign o_frame_done       = fd_q;
    assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_mnist_line_buffer_ctrl.sv
// Directed bench for mnist_line_buffer_ctrl: pixel value = (row*28+col) mod 256,
// windows logged at the falling edge and compared with hand-derived values.
module tb_mnist_line_buffer_ctrl;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic        i_data_valid;
    logic [7:0]  i_data;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid, o_intr, o_frame_done, o_overflow;

    mnist_line_buffer_ctrl #(.IMG_W(28), .DATA_W(8)) dut (
        .axi_clk            (axi_clk),
        .axi_rst            (axi_rst),
        .i_data_valid       (i_data_valid),
        .i_data             (i_data),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr),
        .o_frame_done       (o_frame_done),
        .o_overflow         (o_overflow)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [71:0] d;
        logic        intr;
        logic        fd;
        int          cyc;
    } win_t;

    win_t wq[$];
    int   cyc = 0, intr_cnt = 0, fd_cnt = 0;
    int   checks = 0, errors = 0;

    always @(posedge axi_clk) cyc <= cyc + 1;

    always @(negedge axi_clk) begin
        if (o_intr)       intr_cnt <= intr_cnt + 1;
        if (o_frame_done) fd_cnt   <= fd_cnt + 1;
        if (o_pixel_data_valid) wq.push_back('{o_pixel_data, o_intr, o_frame_done, cyc});
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*8 +: 8] = 8'((r + i) * 28 + c + j);
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge axi_clk); #1; end
    endtask

    task automatic send_pix(input logic [7:0] v);
        i_data_valid = 1'b1;
        i_data       = v;
        @(posedge axi_clk); #1;
        i_data_valid = 1'b0;
    endtask

    task automatic send_row(input int r);
        for (int c = 0; c < 28; c++) send_pix(8'(r * 28 + c));
    endtask

    task automatic wait_win(input string tag, input int n, input int lim);
        int t = 0;
        while (wq.size() < n && t < lim) begin @(posedge axi_clk); #1; t++; end
        chki(tag, int'(wq.size() >= n), 1);
    endtask

    task automatic pulse_reset();
        axi_rst = 1'b1;
        idle(2);
        axi_rst = 1'b0;
        idle(2);
    endtask

    // Sender protocol: 4 rows, then one row per o_intr until 28 rows are sent.
    task automatic run_frame(input string tag);
        int base = wq.size();
        int ib = intr_cnt, fb = fd_cnt;
        int sent = 4, t = 0, ni = 0, last;
        for (int r = 0; r < 4; r++) send_row(r);
        while (sent < 28 && t < 2000) begin
            if (intr_cnt - ib > sent - 4) begin send_row(sent); sent++; end
            else begin idle(1); t++; end
        end
        chki({tag, "_rows_sent"}, sent, 28);
        t = 0;
        while (fd_cnt == fb && t < 200) begin idle(1); t++; end
        idle(3);
        chki({tag, "_windows"}, wq.size() - base, 676);
        chki({tag, "_intr"}, intr_cnt - ib, 26);
        chki({tag, "_frame_done"}, fd_cnt - fb, 1);
        chki({tag, "_overflow"}, int'(o_overflow), 0);
        for (int n = 0; n < 676 && base + n < wq.size(); n++) begin
            chk($sformatf("%s_win%0d", tag, n), wq[base+n].d, exp_win(n / 26, n % 26));
            ni += int'(wq[base+n].intr);
        end
        chki({tag, "_intr_on_windows"}, ni, 26);
        last = base + 675;
        if (last < wq.size()) begin
            chki({tag, "_last_tl"}, int'(wq[last].d[7:0]), 213);
            chki({tag, "_last_fd"}, int'(wq[last].fd), 1);
            chki({tag, "_last_intr"}, int'(wq[last].intr), 1);
        end
    endtask

    initial begin
        int base, ib, ce;
        axi_rst = 1'b1; i_data_valid = 1'b0; i_data = '0;
        idle(2);
        chk ("rst_data",  o_pixel_data, 72'h0);
        chki("rst_valid", int'(o_pixel_data_valid), 0);
        chki("rst_intr",  int'(o_intr), 0);
        chki("rst_fd",    int'(o_frame_done), 0);
        chki("rst_ovf",   int'(o_overflow), 0);
        axi_rst = 1'b0;
        idle(2);

        // Three-row fill: 26 windows, latency and one o_intr on the last window.
        base = wq.size(); ib = intr_cnt;
        for (int r = 0; r < 3; r++) send_row(r);
        ce = cyc;
        idle(40);
        chki("fill_count", wq.size() - base, 26);
        chki("fill_intr", intr_cnt - ib, 1);
        if (wq.size() >= base + 26) begin
            chk ("fill_w0",  wq[base].d,
                 {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0});
            chk ("fill_w25", wq[base+25].d,
                 {8'd83, 8'd82, 8'd81, 8'd55, 8'd54, 8'd53, 8'd27, 8'd26, 8'd25});
            chki("fill_w0_cyc",  wq[base].cyc, ce + 2);
            chki("fill_w25_cyc", wq[base+25].cyc, ce + 27);
            chki("fill_w25_intr", int'(wq[base+25].intr), 1);
            chki("fill_w24_intr", int'(wq[base+24].intr), 0);
        end

        // Fourth row drives out row 1 (next buffer), then reset lands mid-READ.
        base = wq.size();
        send_row(3);
        wait_win("row1_wait", base + 1, 40);
        if (wq.size() > base)
            chk("row1_w0", wq[base].d,
                {8'd86, 8'd85, 8'd84, 8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28});
        idle(3);
        chki("pre_rst_valid", int'(o_pixel_data_valid), 1);
        #2 axi_rst = 1'b1;
        #1;
        chk ("midrst_data",  o_pixel_data, 72'h0);
        chki("midrst_valid", int'(o_pixel_data_valid), 0);
        chki("midrst_intr",  int'(o_intr), 0);
        chki("midrst_fd",    int'(o_frame_done), 0);
        idle(2);
        axi_rst = 1'b0;
        idle(2);

        // Fresh frame after reset, then a back-to-back second frame.
        run_frame("frame1");
        run_frame("frame2");

        // Row completion on the retire edge: rows_filled must stay at 3.
        pulse_reset();
        force dut.state_q = 1'b0;
        for (int r = 0; r < 3; r++) send_row(r);
        send_pix(8'd84);
        release dut.state_q;
        base = wq.size();
        for (int c = 1; c < 28; c++) send_pix(8'(84 + c));
        wait_win("simul_wait", base + 27, 80);
        if (wq.size() >= base + 27) begin
            chk ("simul_w0", wq[base].d, exp_win(0, 0));
            chki("simul_w25_intr", int'(wq[base+25].intr), 1);
            chk ("simul_next_w0", wq[base+26].d, exp_win(1, 0));
            chki("simul_gap", wq[base+26].cyc - wq[base+25].cyc, 2);
        end

        // Overflow: hold reads off, fill 4 rows, push one extra pixel.
        pulse_reset();
        force dut.state_q = 1'b0;
        for (int r = 0; r < 4; r++) send_row(r);
        chki("ovf_before", int'(o_overflow), 0);
        send_pix(8'hEE);
        chki("ovf_set", int'(o_overflow), 1);
        chki("ovf_no_valid", int'(o_pixel_data_valid), 0);
        release dut.state_q;
        base = wq.size();
        wait_win("ovf_wait", base + 52, 120);
        if (wq.size() >= base + 52) begin
            chk("ovf_row0_w0", wq[base].d, exp_win(0, 0));
            chk("ovf_row1_w0", wq[base+26].d, exp_win(1, 0));
        end
        send_row(4);
        wait_win("ovf_row2_wait", base + 53, 40);
        if (wq.size() >= base + 53) chk("ovf_row2_w0", wq[base+52].d, exp_win(2, 0));
        idle(30);
        chki("ovf_sticky", int'(o_overflow), 1);
        pulse_reset();
        chki("ovf_cleared", int'(o_overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mnist_line_buffer_ctrl.md
# mnist_line_buffer_ctrl

Receive-side image controller for the MNIST CNN input path. It accepts the 8-bit, row-major 28x28 pixel stream that the image sender pushes, and stores it in four rotating 28-pixel line buffers. It emits one 3x3 window per cycle for the first convolution layer. At the end of every output row it pulses `o_intr`, which requests the next 28-pixel row from the sender.

## Interface
- `IMG_W`, default 28: pixels per row and rows per frame.
- `DATA_W`, default 8: pixel width.
- `axi_clk`, in, 1: the only clock; all logic is on the rising edge.
- `axi_rst`, in, 1: reset, asynchronous, active-high.
- `i_data_valid`, in, 1: `i_data` holds a pixel this cycle.
- `i_data`, in, `DATA_W`: pixel, row-major, no header.
- `o_pixel_data`, out, 9*`DATA_W`: 3x3 window.
  - Bits [7:0] are top-left, [15:8] top-middle, [23:16] top-right.
  - Bits [31:24] through [47:40] are the middle row, left to right.
  - Bits [55:48] through [71:64] are the bottom row, left to right.
- `o_pixel_data_valid`, out, 1: `o_pixel_data` is valid.
- `o_intr`, out, 1: one-cycle pulse when an output row is finished. It means "send the next row".
- `o_frame_done`, out, 1: one-cycle pulse together with the last `o_intr` of a frame.
- `o_overflow`, out, 1: sticky flag, set when a pixel is dropped. Only reset clears it.

## Operation
**Write side**
- Pointers: `wr_buf` (0..3) and `wr_col` (0..`IMG_W`-1).
- When `i_data_valid` is high, store the pixel at `buf[wr_buf][wr_col]` and increment `wr_col`.
- When `wr_col` wraps from 27 to 0: `wr_buf` increments mod 4, and the row-complete event fires.

**Row accounting**
- `rows_filled` (0..4) holds the number of complete rows not yet retired.
- It increments on row-complete and decrements on row-retire. If both happen in the same cycle, it is unchanged.

**Overflow**
- If `i_data_valid` is high while `rows_filled==4`, the pixel is dropped, the pointers do not move, and `o_overflow` is set.

**Read FSM**
- IDLE:
  - Go to READ when `rows_filled>=3`.
  - `rd_col` is 0.
- READ:
  - Each cycle, form the window from buffers `rd_buf`, `rd_buf+1` and `rd_buf+2` (all mod 4), at columns `rd_col`, `rd_col+1` and `rd_col+2`.
  - Register the window into `o_pixel_data` with valid high.
  - Increment `rd_col`.
  - At `rd_col==IMG_W-3` (the 26th window), retire the row, go to IDLE and pulse `o_intr`:
    - `rd_buf` increments mod 4.
    - `rows_filled` decrements.
    - `out_row` increments.
- Frame end: when the retired row is `out_row==IMG_W-3` (the 26th output row):
  - `o_frame_done` pulses.
  - `out_row` returns to 0.
  - `rd_buf` is set to the post-update `wr_buf`.
  - `rows_filled` is set to 1 if a row completes in this same cycle, otherwise 0.
  - The two leftover rows are discarded.

**Arithmetic and combinational rules**
- All pointer arithmetic is modulo; pointers never leave their range.
- Windows are raw pixels: no padding and no arithmetic.
- The write path never blocks and there is no ready signal. The sender must only send in response to `o_intr`. The initial burst is 4 rows.

## Timing
- Reset values:
  - All outputs are 0.
  - `wr_buf`, `wr_col`, `rd_buf`, `rd_col`, `out_row` and `rows_filled` are 0.
  - FSM is in IDLE.
  - Line buffer contents are don't-care.
- Reset asserted mid-READ: outputs drop to 0 immediately (asynchronous) and the in-flight row is abandoned.
- Latency:
  - Edge E captures the last pixel of the 3rd row.
  - The FSM enters READ at E+1.
  - `o_pixel_data_valid` is high after edge E+2, for exactly 26 consecutive cycles.
- `o_intr` and `o_frame_done` are high in the same cycle as the 26th valid window.
- Between rows, `o_pixel_data_valid` is low for at least 1 cycle (the IDLE cycle).
  - If `rows_filled>=3` after a retire, the next row's first window is 2 cycles after the `o_intr` cycle.
- Writes during READ are legal. The writer only touches buffer `rd_buf+3`, which is never read in the current row.
- Per frame: 676 windows, 26 `o_intr` pulses, 1 `o_frame_done` pulse.

## Test plan
- **Reset:** assert `axi_rst` mid-stream → all outputs 0 within the same cycle; a fresh frame afterwards produces correct windows.
- **3-row fill:** stream pixel value (r*28+c) mod 256, three rows, `i_data_valid` continuous → 26 windows. Required:
  - Window 0 = {58,57,56,30,29,28,2,1,0} (bytes listed MSB..LSB).
  - Window 25 = {83,82,81,55,54,53,27,26,25}.
  - Exactly one `o_intr` pulse, together with window 25.
- **Full sender protocol:** 4 rows, then 28 pixels per `o_intr`, until 784 pixels are sent. Required:
  - 676 windows and 26 `o_intr` pulses.
  - `o_frame_done` pulses once, together with the last window.
  - Last window top-left = (25*28+25) mod 256 = 213.
  - `o_overflow` stays 0.
- **Simultaneous events:** row-complete on the same edge as row-retire → `rows_filled` unchanged. Check next-row window 0 from buffer `rd_buf+1`.
- **Back-to-back frames:** two frames using the full protocol → the second frame's window 0 = {58,57,56,30,29,28,2,1,0}, with no leftover-row contamination.
- **Overflow:** disable reads by holding the FSM path stalled via 4 rows, then one extra pixel while `rows_filled==4` → pixel dropped, `o_overflow`=1 until reset, write pointers unchanged.
